// File: rtl/bus_countdown_timer.sv
// Loadable down-counter: counts a captured start value down to zero on enabled
// cycles, pulses expired on reaching zero, and optionally reloads itself.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not counting; count holds (0 after expiry or reset), busy=0
// RUN   | counting down on enabled cycles, busy=1

module bus_countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic [3:0]       expire_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            reload_value <= '0;
            busy         <= 1'b0;
            expired      <= 1'b0;
            expire_cnt   <= 4'd0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                count        <= load_value;
                reload_value <= load_value;
                if (load_value != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == RUN && enable) begin
                if (count > WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else begin
                    // RUN is only entered with a non-zero value, so this is count==1
                    expired <= 1'b1;
                    if (expire_cnt != 4'd15)
                        expire_cnt <= expire_cnt + 4'd1;
                    if (AUTO_RELOAD) begin
                        count <= reload_value;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_countdown_timer.sv
// Directed bench for bus_countdown_timer: one stopping instance and one
// auto-reloading instance share the stimulus; expected values are hand-derived.

module tb_bus_countdown_timer;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [3:0] load_value;
    logic       enable;

    logic [3:0] count,    count_ar;
    logic       busy,     busy_ar;
    logic       expired,  expired_ar;
    logic [3:0] expire_cnt, expire_cnt_ar;

    int n_vec = 0;
    int n_err = 0;

    bus_countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
        .enable(enable), .count(count), .busy(busy), .expired(expired),
        .expire_cnt(expire_cnt)
    );

    bus_countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
        .enable(enable), .count(count_ar), .busy(busy_ar), .expired(expired_ar),
        .expire_cnt(expire_cnt_ar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one clock edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input int c, input int b,
                              input int e, input int ec);
        check({tag, ".count"},      int'(count),      c);
        check({tag, ".busy"},       int'(busy),       b);
        check({tag, ".expired"},    int'(expired),    e);
        check({tag, ".expire_cnt"}, int'(expire_cnt), ec);
    endtask

    initial begin
        int gap_en[7];
        int gap_cnt[7];
        int gap_exp[7];

        gap_en  = '{1, 0, 0, 1, 1, 0, 1};
        gap_cnt = '{3, 3, 3, 2, 1, 1, 0};
        gap_exp = '{0, 0, 0, 0, 0, 0, 1};

        reset_n    = 1'b0;
        load       = 1'b0;
        load_value = 4'd0;
        enable     = 1'b0;
        #12;
        check_main("reset", 0, 0, 0, 0);
        step();
        reset_n = 1'b1;

        // basic countdown from 3
        load = 1'b1; load_value = 4'd3; enable = 1'b1;
        step();
        check_main("basic.load", 3, 1, 0, 0);
        load = 1'b0;
        step(); check_main("basic.c2", 2, 1, 0, 0);
        step(); check_main("basic.c1", 1, 1, 0, 0);
        step(); check_main("basic.c0", 0, 0, 1, 1);
        step(); check_main("basic.after", 0, 0, 0, 1);

        // gapped enable from 4
        load = 1'b1; load_value = 4'd4; enable = 1'b0;
        step();
        check_main("gap.load", 4, 1, 0, 1);
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            enable = gap_en[i][0];
            step();
            check_main($sformatf("gap.s%0d", i), gap_cnt[i],
                       (i == 6) ? 0 : 1, gap_exp[i], (i == 6) ? 2 : 1);
        end
        enable = 1'b0;

        // load wins over enable and restarts a running count
        load = 1'b1; load_value = 4'd9; enable = 1'b1;
        step();
        check_main("prio.load9", 9, 1, 0, 2);
        load = 1'b0;
        step(); step(); step();
        check_main("prio.at6", 6, 1, 0, 2);
        load = 1'b1; load_value = 4'd2; enable = 1'b1;
        step();
        check_main("prio.reload2", 2, 1, 0, 2);
        load = 1'b0;
        step(); check_main("prio.c1", 1, 1, 0, 2);
        step(); check_main("prio.c0", 0, 0, 1, 3);

        // zero load in IDLE: stays idle, no pulse
        load = 1'b1; load_value = 4'd0; enable = 1'b1;
        step();
        check_main("zero.load", 0, 0, 0, 3);
        load = 1'b0;
        step();
        check_main("zero.idle_en", 0, 0, 0, 3);

        // all-ones load takes 15 enabled cycles
        load = 1'b1; load_value = 4'd15; enable = 1'b0;
        step();
        check_main("max.load", 15, 1, 0, 3);
        load = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            check("max.count", int'(count), 15 - i);
            check("max.expired", int'(expired), 0);
        end
        step();
        check_main("max.expire", 0, 0, 1, 4);

        // asynchronous reset mid-count at 5
        load = 1'b1; load_value = 4'd9; enable = 1'b1;
        step();
        load = 1'b0;
        step(); step(); step(); step();
        check_main("rst.at5", 5, 1, 0, 4);
        #2;
        reset_n = 1'b0;
        #1;
        check_main("rst.async", 0, 0, 0, 0);
        check("rst.ar_count", int'(count_ar), 0);
        check("rst.ar_busy", int'(busy_ar), 0);
        check("rst.ar_cnt", int'(expire_cnt_ar), 0);
        step();
        check_main("rst.held", 0, 0, 0, 0);
        reset_n = 1'b1;
        step();
        check_main("rst.idle", 0, 0, 0, 0);

        // auto-reload with value 2 and expiry-count saturation
        load = 1'b1; load_value = 4'd2; enable = 1'b1;
        step();
        check("ar.load.count", int'(count_ar), 2);
        check("ar.load.busy", int'(busy_ar), 1);
        load = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check($sformatf("ar.k%0d.count", k), int'(count_ar), (k % 2 == 1) ? 1 : 2);
            check($sformatf("ar.k%0d.expired", k), int'(expired_ar), (k % 2 == 1) ? 0 : 1);
            check($sformatf("ar.k%0d.busy", k), int'(busy_ar), 1);
            check($sformatf("ar.k%0d.expire_cnt", k), int'(expire_cnt_ar),
                  (k / 2 > 15) ? 15 : k / 2);
        end
        enable = 1'b0;
        step();
        check("ar.hold.count", int'(count_ar), 2);
        check("ar.hold.expired", int'(expired_ar), 0);
        check("ar.hold.busy", int'(busy_ar), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
